// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, transfer-size codes and the byte-select to size mapping.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ADDR = 3'd1,
    D_DATA = 3'd2,
    I_ADDR = 3'd3,
    I_DATA = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Aligned half-words use the lower or upper lane pair; anything else is a byte.
  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    case (sel)
      4'b1111:         return SIZE_WORD;
      4'b0011, 4'b1100: return SIZE_HALF;
      default:         return SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_sizer.sv
// Combinational translation of M-stage byte enables into port size and write strobes.
module mem_req_sizer
  import mem_arb_pkg::*;
(
  input  logic [3:0] sel,
  input  logic       wr,
  output logic [1:0] size,
  output logic [3:0] wstrb
);

  assign size  = sel_to_size(sel);
  assign wstrb = wr ? sel : 4'b0000;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, sequencing
// address/data phases, holding returned data and producing the fetch/data stalls.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              i_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [1:0]        sz_size;
  logic [3:0]        sz_wstrb;

  mem_req_sizer u_sizer (
    .sel  (data_sel),
    .wr   (data_wr),
    .size (sz_size),
    .wstrb(sz_wstrb)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_size_d   = mem_size_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    i_done_d     = i_done_q & longest_stall;
    d_done_d     = d_done_q & longest_stall;

    case (state_q)
      IDLE: begin
        // The M-stage access is older than the fetch, so it wins a tie.
        if (data_req && !d_done_q) begin
          state_d     = D_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_size_d  = sz_size;
          mem_wstrb_d = sz_wstrb;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
        end else if (inst_req && !i_done_q) begin
          state_d     = I_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_size_d  = SIZE_WORD;
          mem_wstrb_d = 4'b0000;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
        end
      end
      D_ADDR, I_ADDR: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = (state_q == D_ADDR) ? D_DATA : I_DATA;
        end
      end
      D_DATA: begin
        // A flushed requester still lets the bus finish; its result is just dropped.
        if (mem_data_ok) begin
          state_d = IDLE;
          if (data_req) begin
            d_done_d = 1'b1;
            if (!mem_wr_q) data_rdata_d = mem_rdata;
          end
        end
      end
      I_DATA: begin
        if (mem_data_ok) begin
          state_d = IDLE;
          if (inst_req) begin
            i_done_d     = 1'b1;
            inst_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= 2'd0;
      mem_wstrb_q  <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_size_q   <= mem_size_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_size   = mem_size_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign i_stall    = inst_req & ~i_done_q;
  assign d_stall    = data_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: fetch, collision, sizes,
// stall hold, flush and asynchronous reset, with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .i_stall      (i_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_sel     (data_sel),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .d_stall      (d_stall),
    .longest_stall(longest_stall),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One complete data access with first-possible handshakes, then pipeline advance.
  task automatic data_access(input string tag, input logic wr, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [1:0] exp_size,
                             input logic [3:0] exp_wstrb);
    data_req = 1'b1; data_wr = wr; data_sel = sel; data_addr = addr; data_wdata = wdata;
    longest_stall = 1'b1;
    step();
    check({tag, " mem_req"},   {31'd0, mem_req},   32'd1);
    check({tag, " mem_wr"},    {31'd0, mem_wr},    {31'd0, wr});
    check({tag, " mem_size"},  {30'd0, mem_size},  {30'd0, exp_size});
    check({tag, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = rdata;
    step();
    mem_data_ok = 1'b0;
    check({tag, " d_stall done"}, {31'd0, d_stall}, 32'd0);
    data_req = 1'b0; longest_stall = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_sel = 0;
    data_addr = 0; data_wdata = 0; longest_stall = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    #12;
    check("rst mem_req",    {31'd0, mem_req},   32'd0);
    check("rst mem_wr",     {31'd0, mem_wr},    32'd0);
    check("rst mem_size",   {30'd0, mem_size},  32'd0);
    check("rst mem_wstrb",  {28'd0, mem_wstrb}, 32'd0);
    check("rst mem_addr",   mem_addr,           32'd0);
    check("rst mem_wdata",  mem_wdata,          32'd0);
    check("rst inst_rdata", inst_rdata,         32'd0);
    check("rst data_rdata", data_rdata,         32'd0);
    check("rst i_stall",    {31'd0, i_stall},   32'd0);
    check("rst d_stall",    {31'd0, d_stall},   32'd0);
    rst = 1'b0;
    step();

    // Fetch only: addr_ok in cycle 1, data_ok in cycle 3.
    inst_req = 1'b1; inst_addr = 32'hBFC00000; longest_stall = 1'b1;
    step();
    check("fetch c1 mem_req",  {31'd0, mem_req},  32'd1);
    check("fetch c1 mem_addr", mem_addr,          32'hBFC00000);
    check("fetch c1 mem_size", {30'd0, mem_size}, 32'd2);
    check("fetch c1 mem_wr",   {31'd0, mem_wr},   32'd0);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    check("fetch c2 mem_req", {31'd0, mem_req}, 32'd0);
    check("fetch c2 i_stall", {31'd0, i_stall}, 32'd1);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08BFAF;
    step();
    mem_data_ok = 1'b0;
    check("fetch c4 i_stall",    {31'd0, i_stall}, 32'd0);
    check("fetch c4 inst_rdata", inst_rdata,        32'h3C08BFAF);
    inst_req = 1'b0; longest_stall = 1'b0;
    step();
    check("fetch idle mem_req", {31'd0, mem_req}, 32'd0);

    // Collision: store wins, fetch follows after the store's data_ok.
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b1; data_sel = 4'b1111;
    data_addr = 32'h80001000; data_wdata = 32'h12345678; longest_stall = 1'b1;
    step();
    check("coll mem_req",   {31'd0, mem_req},   32'd1);
    check("coll mem_wr",    {31'd0, mem_wr},    32'd1);
    check("coll mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    check("coll mem_addr",  mem_addr,           32'h80001000);
    check("coll mem_wdata", mem_wdata,          32'h12345678);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    check("coll d_data i_stall", {31'd0, i_stall}, 32'd1);
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_data_ok = 1'b0;
    check("coll store done d_stall",  {31'd0, d_stall}, 32'd0);
    check("coll no fetch yet",        {31'd0, mem_req}, 32'd0);
    step();
    check("coll fetch mem_req",  {31'd0, mem_req}, 32'd1);
    check("coll fetch mem_addr", mem_addr,          32'hBFC00004);
    check("coll fetch mem_wr",   {31'd0, mem_wr},  32'd0);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h24020001;
    step();
    mem_data_ok = 1'b0;
    check("coll fetch inst_rdata", inst_rdata, 32'h24020001);
    inst_req = 1'b0; data_req = 1'b0; longest_stall = 1'b0;
    step();

    // Byte / half sizing.
    data_access("lb", 1'b0, 4'b0001, 32'h80000010, 32'h0, 32'h000000A5, 2'd0, 4'b0000);
    check("lb data_rdata", data_rdata, 32'h000000A5);
    data_access("sb", 1'b1, 4'b0100, 32'h80000012, 32'h00AB0000, 32'hDEADBEEF, 2'd0, 4'b0100);
    check("sb data_rdata held", data_rdata, 32'h000000A5);
    data_access("sh", 1'b1, 4'b1100, 32'h80000016, 32'hBEEF0000, 32'hDEADBEEF, 2'd1, 4'b1100);

    // Stall hold: fetch finishes while the load is still pending.
    inst_req = 1'b1; inst_addr = 32'hBFC00008; longest_stall = 1'b1;
    step();
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111; data_addr = 32'h80002000;
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_data_ok = 1'b0;
    check("hold i_stall",    {31'd0, i_stall}, 32'd0);
    check("hold d_stall",    {31'd0, d_stall}, 32'd1);
    check("hold inst_rdata", inst_rdata,        32'h11111111);
    step();
    check("hold load mem_addr", mem_addr,         32'h80002000);
    check("hold load mem_wr",   {31'd0, mem_wr},  32'd0);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_data_ok = 1'b0;
    check("hold data_rdata", data_rdata, 32'h22222222);
    step();
    check("hold no refetch",        {31'd0, mem_req}, 32'd0);
    check("hold inst_rdata stable", inst_rdata,        32'h11111111);
    check("hold i_stall still low", {31'd0, i_stall}, 32'd0);
    longest_stall = 1'b0;
    step();
    check("hold i_done cleared", {31'd0, i_stall}, 32'd1);
    check("hold d_done cleared", {31'd0, d_stall}, 32'd1);
    inst_req = 1'b0; data_req = 1'b0;
    step();
    check("hold idle mem_req", {31'd0, mem_req}, 32'd0);

    // Flush mid-fetch: inst_req drops during the data phase.
    inst_req = 1'b1; inst_addr = 32'hBFC0000C; longest_stall = 1'b1;
    step();
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h99999999;
    step();
    mem_data_ok = 1'b0;
    check("flush inst_rdata", inst_rdata,        32'h11111111);
    check("flush mem_req",    {31'd0, mem_req}, 32'd0);
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    #1;
    check("flush i_done low", {31'd0, i_stall}, 32'd1);
    step();
    check("flush reissue mem_req",  {31'd0, mem_req}, 32'd1);
    check("flush reissue mem_addr", mem_addr,          32'hBFC00010);
    // addr_ok and data_ok together in the address phase: data_ok ignored.
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    check("same-cycle ok inst_rdata", inst_rdata,        32'h11111111);
    check("same-cycle ok i_stall",    {31'd0, i_stall}, 32'd1);
    mem_data_ok = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_data_ok = 1'b0;
    check("same-cycle ok final rdata", inst_rdata, 32'h55AA55AA);
    inst_req = 1'b0; longest_stall = 1'b0;
    step();

    // Asynchronous reset while in D_DATA.
    data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b1111; data_addr = 32'h80003000;
    longest_stall = 1'b1;
    step();
    check("arst pre mem_size", {30'd0, mem_size}, 32'd2);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; data_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst mem_addr",   mem_addr,           32'd0);
    check("arst mem_size",   {30'd0, mem_size},  32'd0);
    check("arst data_rdata", data_rdata,         32'd0);
    check("arst inst_rdata", inst_rdata,         32'd0);
    step();
    rst = 1'b0; mem_data_ok = 1'b1;
    step();
    mem_data_ok = 1'b0;
    check("arst idle mem_req",  {31'd0, mem_req}, 32'd0);
    check("arst idle rdata",    data_rdata,        32'd0);
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    step();
    check("arst fetch mem_req",  {31'd0, mem_req}, 32'd1);
    check("arst fetch mem_addr", mem_addr,          32'hBFC00000);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08BFAF;
    step();
    mem_data_ok = 1'b0;
    check("arst fetch inst_rdata", inst_rdata, 32'h3C08BFAF);
    inst_req = 1'b0; longest_stall = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
